mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter ACK_TIMEOUT, default 15, max BUSY cycles awaiting mem_ack before abort (1..255).
REQ-002 Parameter ERR_DATA, default 16'hDEAD, write-back value returned for an aborted read.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 we_mem_MEM, re_mem_MEM  in  1 each  store/load request from EX/MEM register.
REQ-006 alu_result_MEM  in  16  memory address, or ALU write-back value.
REQ-007 sdata_MEM  in  16  store data.
REQ-008 wb_sel_MEM, we_rf_MEM, hlt_MEM  in  1 each  write-back select (1 = memory data), RF write enable, halt.
REQ-009 dst_addr_MEM  in  4  destination register.
REQ-010 mem_req, mem_we  out  1 each  data-memory request, write qualifier.
REQ-011 mem_addr, mem_wdata  out  16 each  address, write data.
REQ-012 mem_rdata  in  16; mem_ack  in  1  read data and completion strobe from memory.
REQ-013 stall  out  1  hold request to EX/MEM and earlier stages.
REQ-014 wb_data_WB  out  16; dst_addr_WB  out  4; we_rf_WB, hlt_WB  out  1 each  MEM/WB register outputs.
REQ-015 mem_err  out  1  sticky timeout flag.

Function
REQ-016 FSM states SHALL be IDLE and BUSY; access = we_mem_MEM | re_mem_MEM.
REQ-017 IDLE: access=1 SHALL go to BUSY next edge and clear the timeout counter; access=0 SHALL stay IDLE.
REQ-018 BUSY: mem_ack=1 SHALL return to IDLE; counter reaching ACK_TIMEOUT with mem_ack=0 SHALL return to IDLE, set mem_err.
REQ-019 mem_req SHALL be 1 exactly while in BUSY; mem_addr=alu_result_MEM, mem_wdata=sdata_MEM, mem_we=we_mem_MEM, all combinational.
REQ-020 we_mem_MEM and re_mem_MEM both 1 SHALL be treated as a store.
REQ-021 stall SHALL be 1 when (IDLE and access) or (BUSY and no completion); 0 on the completion cycle (ack or timeout) and in IDLE without access.
REQ-022 Minimum access latency SHALL be 2 cycles (issue + ack in first BUSY cycle); non-memory instructions SHALL incur 0 stall.
REQ-023 On each edge with stall=0, MEM/WB SHALL load dst_addr_MEM, we_rf_MEM, hlt_MEM and wb_data_WB = wb_sel_MEM ? read value : alu_result_MEM.
REQ-024 Read value SHALL be mem_rdata on the ack cycle, ERR_DATA on a timeout completion.
REQ-025 On each edge with stall=1, MEM/WB SHALL load a bubble: we_rf_WB=0, hlt_WB=0, dst_addr_WB=0, wb_data_WB=0.
REQ-026 mem_ack in IDLE SHALL be ignored.
REQ-027 mem_ack on the same cycle the counter hits ACK_TIMEOUT: ack SHALL win, mem_err unchanged.
REQ-028 mem_err SHALL remain 1 until reset.
REQ-029 Access after timeout SHALL proceed normally (new BUSY, counter cleared).

Reset
REQ-030 rst=1 SHALL immediately force IDLE, counter 0, mem_err 0, MEM/WB outputs all 0, independent of clk.
REQ-031 rst asserted mid-BUSY SHALL drop mem_req the same cycle; pending access is discarded.
REQ-032 After rst release, first posedge SHALL evaluate IDLE rules.

Structure
REQ-033 State encoding, ERR_DATA default and 16-bit/4-bit width constants SHALL live in the shared processor package.
REQ-034 MEM/WB register SHALL be a sub-module mem_wb_ff (load/bubble select input); FSM and counter stay in mem_access_ctrl.

Verification
REQ-035 ALU op, we_rf=1, alu_result=16'h0042, dst=3 -> stall=0; next edge wb_data_WB=0042, dst_addr_WB=3, we_rf_WB=1.
REQ-036 Load addr 16'h0010, ack on 1st BUSY cycle with rdata 16'hBEEF -> stall 1,0; mem_req one cycle; wb_data_WB=BEEF after 2 edges.
REQ-037 Store addr 16'h0020, sdata 16'h1234, ack after 3 BUSY cycles -> mem_we=1, mem_wdata=1234, stall 4 cycles, bubbles in WB, we_rf_WB=0.
REQ-038 Load, no ack -> mem_req 15 cycles, mem_err=1, wb_data_WB=DEAD; ack at cycle 15 instead -> mem_err=0, rdata written back.
REQ-039 rst pulse mid-BUSY -> mem_req=0 immediately, all outputs 0; later load completes normally.
REQ-040 Back-to-back loads, ack each first BUSY cycle -> each completes in 2 cycles, stall pattern 1,0,1,0.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared widths, FSM encoding and MEM/WB payload for the memory stage
package mem_access_ctrl_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;
    localparam int CNT_W      = 8;

    localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 16'hDEAD;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mac_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]     wb_data;
        logic [REG_ADDR_W-1:0] dst_addr;
        logic                  we_rf;
        logic                  hlt;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

    function automatic logic [DATA_W-1:0] wb_select(
        input logic              sel_mem,
        input logic [DATA_W-1:0] mem_val,
        input logic [DATA_W-1:0] alu_val
    );
        return sel_mem ? mem_val : alu_val;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_mem_wb_ff.sv
// rtl/mem_access_ctrl_mem_wb_ff.sv - MEM/WB pipeline register, loads payload or a bubble each edge
module mem_wb_ff
    import mem_access_ctrl_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  mem_wb_t d,
    output mem_wb_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= MEM_WB_BUBBLE;
        end else if (load) begin
            q <= d;
        end else begin
            q <= MEM_WB_BUBBLE;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - data-memory access FSM with ack timeout, stall generation and MEM/WB register
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int                ACK_TIMEOUT = 15,
    parameter logic [DATA_W-1:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_mem_MEM,
    input  logic                  re_mem_MEM,
    input  logic [DATA_W-1:0]     alu_result_MEM,
    input  logic [DATA_W-1:0]     sdata_MEM,
    input  logic                  wb_sel_MEM,
    input  logic                  we_rf_MEM,
    input  logic                  hlt_MEM,
    input  logic [REG_ADDR_W-1:0] dst_addr_MEM,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_ack,
    output logic                  stall,
    output logic [DATA_W-1:0]     wb_data_WB,
    output logic [REG_ADDR_W-1:0] dst_addr_WB,
    output logic                  we_rf_WB,
    output logic                  hlt_WB,
    output logic                  mem_err
);

    mac_state_e        state;
    mac_state_e        state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              access;
    logic              is_busy;
    logic              timeout_hit;
    logic              complete;
    logic [DATA_W-1:0] read_val;
    mem_wb_t           wb_d;
    mem_wb_t           wb_q;

    assign access  = we_mem_MEM | re_mem_MEM;
    assign is_busy = (state == ST_BUSY);

    // cnt holds completed BUSY cycles, so the current cycle is number cnt+1
    assign timeout_hit = is_busy &&
                         (({1'b0, cnt} + 1'b1) == (CNT_W+1)'(ACK_TIMEOUT));
    assign complete    = is_busy && (mem_ack || timeout_hit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (access) state_nxt = ST_BUSY;
            ST_BUSY: if (complete) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_req = 1'b0;
        stall   = 1'b0;
        case (state)
            ST_IDLE: stall = access;
            ST_BUSY: begin
                mem_req = 1'b1;
                stall   = !complete;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!is_busy) begin
            cnt <= '0;
        end else if (!complete) begin
            cnt <= cnt + 1'b1;
        end
    end

    // ack on the timeout cycle wins, so the flag only sets on a genuine abort
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_err <= 1'b0;
        end else if (timeout_hit && !mem_ack) begin
            mem_err <= 1'b1;
        end
    end

    assign mem_addr  = alu_result_MEM;
    assign mem_wdata = sdata_MEM;
    assign mem_we    = we_mem_MEM;

    assign read_val = (is_busy && mem_ack) ? mem_rdata : ERR_DATA;

    always_comb begin
        wb_d          = MEM_WB_BUBBLE;
        wb_d.wb_data  = wb_select(wb_sel_MEM, read_val, alu_result_MEM);
        wb_d.dst_addr = dst_addr_MEM;
        wb_d.we_rf    = we_rf_MEM;
        wb_d.hlt      = hlt_MEM;
    end

    mem_wb_ff u_mem_wb_ff (
        .clk  (clk),
        .rst  (rst),
        .load (!stall),
        .d    (wb_d),
        .q    (wb_q)
    );

    assign wb_data_WB  = wb_q.wb_data;
    assign dst_addr_WB = wb_q.dst_addr;
    assign we_rf_WB    = wb_q.we_rf;
    assign hlt_WB      = wb_q.hlt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        we_mem_MEM, re_mem_MEM;
    logic [15:0] alu_result_MEM, sdata_MEM;
    logic        wb_sel_MEM, we_rf_MEM, hlt_MEM;
    logic [3:0]  dst_addr_MEM;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [15:0] wb_data_WB;
    logic [3:0]  dst_addr_WB;
    logic        we_rf_WB, hlt_WB;
    logic        mem_err;

    int tests = 0;
    int fails = 0;
    logic [21:0] exp_q[$];
    logic [21:0] exp_w;

    mem_access_ctrl #(.ACK_TIMEOUT(15), .ERR_DATA(16'hDEAD)) dut (
        .clk            (clk),
        .rst            (rst),
        .we_mem_MEM     (we_mem_MEM),
        .re_mem_MEM     (re_mem_MEM),
        .alu_result_MEM (alu_result_MEM),
        .sdata_MEM      (sdata_MEM),
        .wb_sel_MEM     (wb_sel_MEM),
        .we_rf_MEM      (we_rf_MEM),
        .hlt_MEM        (hlt_MEM),
        .dst_addr_MEM   (dst_addr_MEM),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .stall          (stall),
        .wb_data_WB     (wb_data_WB),
        .dst_addr_WB    (dst_addr_WB),
        .we_rf_WB       (we_rf_WB),
        .hlt_WB         (hlt_WB),
        .mem_err        (mem_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // WB monitor: every non-bubble MEM/WB value must match the next expected entry
    always @(negedge clk) begin
        if (!rst && (we_rf_WB || hlt_WB || dst_addr_WB != 4'd0 || wb_data_WB != 16'd0)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL wb_unexpected: got %h, required no output",
                         {wb_data_WB, dst_addr_WB, we_rf_WB, hlt_WB});
            end else begin
                exp_w = exp_q.pop_front();
                check("wb_out", {10'd0, wb_data_WB, dst_addr_WB, we_rf_WB, hlt_WB}, {10'd0, exp_w});
            end
        end
    end

    task automatic clear_inputs();
        we_mem_MEM = 0; re_mem_MEM = 0; alu_result_MEM = 0; sdata_MEM = 0;
        wb_sel_MEM = 0; we_rf_MEM = 0; hlt_MEM = 0; dst_addr_MEM = 0;
        mem_ack = 0; mem_rdata = 16'h5A5A;
    endtask

    task automatic alu_op(input logic [15:0] data, input logic [3:0] dst,
                          input logic we, input logic hlt);
        @(posedge clk); #1;
        alu_result_MEM = data; dst_addr_MEM = dst; we_rf_MEM = we; hlt_MEM = hlt;
        exp_q.push_back({data, dst, we, hlt});
        @(negedge clk);
        check("alu_stall", stall, 0);
        check("alu_mem_req", mem_req, 0);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic mem_op(input string tag, input logic st, input logic ld,
                          input logic [15:0] addr, input logic [15:0] sd,
                          input int ack_at, input logic [15:0] rd,
                          input logic sel, input logic we, input logic [3:0] dst,
                          input int exp_busy, input logic [21:0] exp_wb);
        int busy = 0;
        int n_stall = 1;
        bit done = 0;
        @(posedge clk); #1;
        we_mem_MEM = st; re_mem_MEM = ld; alu_result_MEM = addr; sdata_MEM = sd;
        wb_sel_MEM = sel; we_rf_MEM = we; dst_addr_MEM = dst;
        exp_q.push_back(exp_wb);
        @(negedge clk);
        check({tag, "_issue_stall"}, stall, 1);
        check({tag, "_issue_req"}, mem_req, 0);
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #1;
            mem_ack   = (k == ack_at);
            mem_rdata = (k == ack_at) ? rd : 16'h5A5A;
            @(negedge clk);
            if (mem_req) busy++;
            if (k == 1) begin
                check({tag, "_addr"}, mem_addr, addr);
                check({tag, "_we"}, mem_we, st);
                if (st) check({tag, "_wdata"}, mem_wdata, sd);
            end
            if (!stall) begin
                done = 1;
                break;
            end
            n_stall++;
        end
        check({tag, "_done"}, done, 1);
        check({tag, "_busy_cycles"}, busy, exp_busy);
        check({tag, "_stall_cycles"}, n_stall, exp_busy);
        @(posedge clk); #1;
        clear_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_inputs();
        #2;
        check("rst_wb_data", wb_data_WB, 0);
        check("rst_we_rf", we_rf_WB, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_err", mem_err, 0);
        check("rst_stall", stall, 0);
        #10 rst = 0;

        alu_op(16'h0042, 4'd3, 1, 0);
        alu_op(16'h00AA, 4'd0, 0, 1);

        mem_op("ld_fast", 0, 1, 16'h0010, 16'h0000, 1, 16'hBEEF, 1, 1, 4'd5, 1,
               {16'hBEEF, 4'd5, 1'b1, 1'b0});
        mem_op("st_slow", 1, 0, 16'h0020, 16'h1234, 4, 16'h0000, 0, 0, 4'd0, 4,
               {16'h0020, 4'd0, 1'b0, 1'b0});
        mem_op("st_both", 1, 1, 16'h0030, 16'h5678, 1, 16'h0000, 0, 0, 4'd0, 1,
               {16'h0030, 4'd0, 1'b0, 1'b0});

        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 16'hFFFF;
        @(negedge clk);
        check("idle_ack_req", mem_req, 0);
        check("idle_ack_stall", stall, 0);
        @(posedge clk); #1;
        clear_inputs();

        mem_op("ld_ack15", 0, 1, 16'h0040, 16'h0000, 15, 16'hC0DE, 1, 1, 4'd7, 15,
               {16'hC0DE, 4'd7, 1'b1, 1'b0});
        @(negedge clk);
        check("ack15_err", mem_err, 0);

        mem_op("ld_tmo", 0, 1, 16'h0050, 16'h0000, 0, 16'h0000, 1, 1, 4'd8, 15,
               {16'hDEAD, 4'd8, 1'b1, 1'b0});
        @(negedge clk);
        check("tmo_err", mem_err, 1);

        mem_op("ld_after", 0, 1, 16'h0060, 16'h0000, 2, 16'h1111, 1, 1, 4'd9, 2,
               {16'h1111, 4'd9, 1'b1, 1'b0});
        @(negedge clk);
        check("err_sticky", mem_err, 1);

        @(posedge clk); #1;
        re_mem_MEM = 1; alu_result_MEM = 16'h0070; wb_sel_MEM = 1; we_rf_MEM = 1; dst_addr_MEM = 4'd1;
        exp_q.push_back({16'hAAAA, 4'd1, 1'b1, 1'b0});
        @(negedge clk);
        check("b2b_stall0", stall, 1);
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 16'hAAAA;
        @(negedge clk);
        check("b2b_stall1", stall, 0);
        check("b2b_req1", mem_req, 1);
        @(posedge clk); #1;
        mem_ack = 0; alu_result_MEM = 16'h0072; dst_addr_MEM = 4'd2;
        exp_q.push_back({16'hBBBB, 4'd2, 1'b1, 1'b0});
        @(negedge clk);
        check("b2b_stall2", stall, 1);
        check("b2b_req2", mem_req, 0);
        @(posedge clk); #1;
        mem_ack = 1; mem_rdata = 16'hBBBB;
        @(negedge clk);
        check("b2b_stall3", stall, 0);
        @(posedge clk); #1;
        clear_inputs();

        @(posedge clk); #1;
        re_mem_MEM = 1; alu_result_MEM = 16'h0080; wb_sel_MEM = 1; we_rf_MEM = 1; dst_addr_MEM = 4'd6;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_req", mem_req, 1);
        #2 rst = 1;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_wb", {wb_data_WB, dst_addr_WB, we_rf_WB, hlt_WB}, 0);
        check("mid_rst_err", mem_err, 0);
        clear_inputs();
        @(posedge clk); #1;
        rst = 0;

        mem_op("ld_post_rst", 0, 1, 16'h0090, 16'h0000, 1, 16'h2222, 1, 1, 4'd4, 1,
               {16'h2222, 4'd4, 1'b1, 1'b0});

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
